// File: rtl/grant_burst_ctrl_if.sv
// Handshake bundle between the arbiter side and grant_burst_ctrl.
// The arbiter/environment drives gnt and len; the controller drives everything else.
interface grant_burst_ctrl_if #(
  parameter int N  = 4,
  parameter int LW = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  gnt;
  logic [LW-1:0] len;
  logic [N-1:0]  req_mask;
  logic [OW-1:0] owner;
  logic          busy;
  logic          beat;
  logic          last;
  logic [N-1:0]  ack;
  logic          err;

  modport master (
    output gnt, len,
    input  req_mask, owner, busy, beat, last, ack, err
  );

  modport slave (
    input  gnt, len,
    output req_mask, owner, busy, beat, last, ack, err
  );
endinterface

// File: rtl/grant_burst_ctrl.sv
// Locks ownership to a one-hot grant for a programmable burst of beats, acks the
// owner at burst end and masks that owner's request so it cannot win back-to-back.
module grant_burst_ctrl #(
  parameter int N  = 4,
  parameter int LW = 4
) (
  input  logic               c,
  input  logic               r,
  grant_burst_ctrl_if.slave  bus
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BURST   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] owner_q, owner_d;
  logic          err_q, err_d;

  logic          gnt_any;
  logic          gnt_onehot;
  logic [OW-1:0] gnt_idx;
  logic [LW-1:0] len_eff;
  logic [N-1:0]  owner_oh;

  // Grant decode: a vector is one-hot when it is non-zero and clearing its
  // lowest set bit leaves nothing behind.
  always_comb begin
    gnt_any    = |bus.gnt;
    gnt_onehot = gnt_any && ((bus.gnt & (bus.gnt - N'(1))) == '0);
    gnt_idx    = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.gnt[i]) gnt_idx = OW'(i);
    end
    len_eff = (bus.len == '0) ? LW'(1) : bus.len;
  end

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_onehot) begin
          owner_d = gnt_idx;
          cnt_d   = len_eff;
          state_d = S_BURST;
        end else if (gnt_any) begin
          err_d = 1'b1;
        end
      end
      S_BURST: begin
        // cnt stops at 1 on the last beat; it is reloaded on the next accept.
        if (cnt_q == LW'(1)) begin
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its peers; the async reset drops an in-flight burst
  // with no ack because the ack is decoded from the RELEASE state only.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded straight from registered state so they are glitch-free.
  always_comb begin
    owner_oh     = N'(1) << owner_q;
    bus.busy     = (state_q != S_IDLE);
    bus.beat     = (state_q == S_BURST);
    bus.last     = (state_q == S_BURST) && (cnt_q == LW'(1));
    bus.ack      = (state_q == S_RELEASE) ? owner_oh : '0;
    bus.req_mask = (state_q == S_IDLE) ? '1 : ~owner_oh;
    bus.owner    = owner_q;
    bus.err      = err_q;
  end

`ifndef SYNTHESIS
  a_cnt_nonzero : assert property (@(posedge c) disable iff (!r)
    (state_q == S_BURST) |-> (cnt_q != '0));
  a_ack_onehot : assert property (@(posedge c) disable iff (!r)
    $onehot0(bus.ack));
`endif

endmodule

// File: doc/grant_burst_ctrl.md
# grant_burst_ctrl

Downstream consumer of the 4-requester fixed-priority arbiter. It takes the registered one-hot grant vector, locks ownership to the granted requester for a programmable burst of beats, and pulses a per-requester acknowledge at burst end. While a burst is active it drives a request mask back to the arbiter's request inputs. That mask stops the current owner from being re-granted back-to-back, so a lower-priority requester can win the slot that follows a release.

## Interface
- `N`, default 4: number of requesters, equal to the arbiter width.
- `LW`, default 4: width of the burst-length input.
- `c`, input, 1: clock. All state updates on the rising edge.
- `r`, input, 1: reset. Asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `gnt`, input, N: grant vector from the arbiter, registered upstream.
- `len`, input, LW: beats per burst. Sampled only when a grant is accepted. A value of 0 is treated as 1.
- `req_mask`, output, N: AND-mask applied to the arbiter's requests. 1 means the request passes.
- `owner`, output, $clog2(N): index of the current owner. Valid while `busy` is 1.
- `busy`, output, 1: high in BURST and RELEASE.
- `beat`, output, 1: high for one cycle per data beat.
- `last`, output, 1: high together with `beat` on the final beat.
- `ack`, output, N: one-cycle pulse to the owner, issued in RELEASE.
- `err`, output, 1: sticky flag set by a multi-hot `gnt` seen in IDLE. Cleared only by reset.

## Operation
- FSM states: IDLE, BURST, RELEASE.
- IDLE:
  - `gnt` zero: stay in IDLE.
  - `gnt` exactly one-hot: capture its index into `owner`, load `cnt` = (len==0 ? 1 : len), go to BURST.
  - `gnt` multi-hot: set `err`, capture nothing, stay in IDLE.
- BURST:
  - `beat`=1 every cycle and `cnt` decrements.
  - When `cnt`==1, assert `last`=1 and go to RELEASE.
  - `gnt` is ignored for the whole state.
- RELEASE:
  - `ack[owner]`=1 for exactly one cycle, `beat`=0, then go to IDLE.
  - `gnt` is ignored.
- Request mask:
  - `req_mask` is all ones in IDLE.
  - In BURST and RELEASE, `req_mask` = ~(1<<owner).
  - Because the arbiter is registered, the first `gnt` seen in IDLE after a release was computed with the owner masked. The previous owner therefore cannot own two consecutive bursts while any other request is pending.
- Counter `cnt` is LW bits wide. It never wraps: the load is never 0 and it stops at 1.
- `owner` holds its value after RELEASE until the next accept. Its value is a don't-care while `busy`=0.
- Reset (`r`=0), at any time including mid-burst:
  - Immediately forces IDLE.
  - Clears `cnt`, `owner`, `busy`, `beat`, `last`, `ack` and `err` to 0.
  - Sets `req_mask` to all ones.
  - No `ack` is issued for a burst aborted by reset.

## Timing
- Accept: a one-hot `gnt` sampled at edge k in IDLE gives `busy`=1 and the first `beat` in cycle k+1.
- A burst of length L occupies cycles k+1 .. k+L. `last` is high in cycle k+L.
- RELEASE is cycle k+L+1, with `ack` high there.
- IDLE is entered at cycle k+L+2. Minimum grant-to-grant spacing is L+2 cycles.
- All outputs are registered or decoded directly from state, so they are glitch-free relative to `c`.
- `len` changes during a burst have no effect.
- If `gnt` goes to zero during BURST, the burst still completes. If `gnt` is still set in IDLE, it is accepted again.

## Test plan
- Reset then idle: `r`=0 for 2 cycles, `gnt`=0000 -> all outputs 0, `req_mask`=1111. Release `r` -> still idle.
- Single burst: `gnt`=0100, `len`=3 -> `owner`=2; `beat` for 3 cycles with `last` on the 3rd; `ack`=0100 in the next cycle; `req_mask`=1011 during `busy`.
- Length zero: `gnt`=0001, `len`=0 -> exactly 1 beat with `last`=1, then `ack`=0001.
- Fairness with arbiter: `req`=1001 held, `len`=2 -> grant order 1000, 0001, 1000. `ack` pulses alternate, and the owner is never served twice in a row.
- Error flag: `gnt`=0110 in IDLE -> `err`=1 next cycle, `busy` stays 0. `err` stays set through later valid bursts until `r`=0.
- Reset mid-burst: `gnt`=1000, `len`=8, assert `r`=0 after 3 beats -> `busy`, `beat` and `ack` drop immediately with no `ack` pulse, and `req_mask`=1111.
